// File: rtl/gerenciador_tiros_param_if.sv
// Request/response bundle of the shot manager: commands, ship position,
// slot read port and status flags.
interface gerenciador_tiros_param_if #(
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned COORD_W = 4
);
    logic               iniciar;
    logic               tiro;
    logic [1:0]         direcao;
    logic [COORD_W-1:0] nave_x;
    logic [COORD_W-1:0] nave_y;
    logic               mover;
    logic               remover;
    logic [IDX_W-1:0]   remover_idx;
    logic [IDX_W-1:0]   consulta_idx;
    logic [COORD_W-1:0] consulta_x;
    logic [COORD_W-1:0] consulta_y;
    logic               consulta_valido;
    logic [IDX_W:0]     num_tiros;
    logic               cheio;
    logic               pronto;
    logic               descartado;
    logic [3:0]         db_estado;

    modport master (
        output iniciar, tiro, direcao, nave_x, nave_y, mover, remover,
               remover_idx, consulta_idx,
        input  consulta_x, consulta_y, consulta_valido, num_tiros, cheio,
               pronto, descartado, db_estado
    );

    modport slave (
        input  iniciar, tiro, direcao, nave_x, nave_y, mover, remover,
               remover_idx, consulta_idx,
        output consulta_x, consulta_y, consulta_valido, num_tiros, cheio,
               pronto, descartado, db_estado
    );
endinterface

// File: rtl/gerenciador_tiros_param.sv
// Shot manager: table of 2**IDX_W shots on a 2**COORD_W square grid.
// Optional macro TIROS_WRAP_EN: shots leaving the grid wrap around instead
// of being invalidated.
module gerenciador_tiros_param #(
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned COORD_W = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    gerenciador_tiros_param_if.slave   bus
);
    localparam int unsigned N     = 2 ** IDX_W;
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [2:0] INICIAL  = 3'd0;
    localparam logic [2:0] ESPERA   = 3'd1;
    localparam logic [2:0] REGISTRA = 3'd2;
    localparam logic [2:0] MOVE     = 3'd3;
    localparam logic [2:0] FIM      = 3'd4;

    logic [2:0]         r_estado;
    logic [N-1:0]       r_valid;
    logic [COORD_W-1:0] r_x   [N];
    logic [COORD_W-1:0] r_y   [N];
    logic [1:0]         r_dir [N];
    logic [1:0]         r_lat_dir;
    logic [COORD_W-1:0] r_lat_x;
    logic [COORD_W-1:0] r_lat_y;
    logic [IDX_W-1:0]   r_idx;
    logic               r_pronto;
    logic               r_descartado;

    logic [2:0]         w_prox;
    logic               w_limpa;
    logic               w_remove;
    logic               w_lat;
    logic               w_grava;
    logic               w_descarta;
    logic               w_zera_idx;
    logic               w_passo;
    logic               w_tem_livre;
    logic [IDX_W-1:0]   w_livre_idx;
    logic [COORD_W-1:0] w_novo_x;
    logic [COORD_W-1:0] w_novo_y;
    logic               w_sai;
    logic [CNT_W-1:0]   w_num;

    // Lowest-index free slot for the next registered shot
    always_comb begin
        w_tem_livre = 1'b0;
        w_livre_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_tem_livre = 1'b1;
                w_livre_idx = IDX_W'(i);
            end
        end
    end

    // One-cell step of the slot under the move scan, with grid-exit detect
    always_comb begin
        w_novo_x = r_x[r_idx];
        w_novo_y = r_y[r_idx];
        w_sai    = 1'b0;
        case (r_dir[r_idx])
            2'b00: begin
                w_novo_y = r_y[r_idx] + COORD_W'(1);
                w_sai    = (r_y[r_idx] == '1);
            end
            2'b01: begin
                w_novo_x = r_x[r_idx] + COORD_W'(1);
                w_sai    = (r_x[r_idx] == '1);
            end
            2'b10: begin
                w_novo_y = r_y[r_idx] - COORD_W'(1);
                w_sai    = (r_y[r_idx] == '0);
            end
            default: begin
                w_novo_x = r_x[r_idx] - COORD_W'(1);
                w_sai    = (r_x[r_idx] == '0);
            end
        endcase
    end

    // Next state and datapath controls; requests only honoured in ESPERA
    always_comb begin
        w_prox     = r_estado;
        w_limpa    = 1'b0;
        w_remove   = 1'b0;
        w_lat      = 1'b0;
        w_grava    = 1'b0;
        w_descarta = 1'b0;
        w_zera_idx = 1'b0;
        w_passo    = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (bus.iniciar) begin
                    w_limpa = 1'b1;
                    w_prox  = ESPERA;
                end
            end
            ESPERA: begin
                if (bus.iniciar) begin
                    w_limpa = 1'b1;
                end else if (bus.remover) begin
                    w_remove = 1'b1;
                end else if (bus.tiro) begin
                    w_lat  = 1'b1;
                    w_prox = REGISTRA;
                end else if (bus.mover) begin
                    w_zera_idx = 1'b1;
                    w_prox     = MOVE;
                end
            end
            REGISTRA: begin
                w_grava    = w_tem_livre;
                w_descarta = !w_tem_livre;
                w_prox     = FIM;
            end
            MOVE: begin
                w_passo = 1'b1;
                if (r_idx == IDX_W'(N - 1)) begin
                    w_prox = FIM;
                end
            end
            FIM: begin
                w_prox = ESPERA;
            end
            default: begin
                w_prox = INICIAL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Slot table, latched request, scan index and pulse outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid      <= '0;
            r_lat_dir    <= '0;
            r_lat_x      <= '0;
            r_lat_y      <= '0;
            r_idx        <= '0;
            r_pronto     <= 1'b0;
            r_descartado <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_x[i]   <= '0;
                r_y[i]   <= '0;
                r_dir[i] <= '0;
            end
        end else begin
            r_pronto     <= (w_prox == FIM);
            r_descartado <= w_descarta;
            if (w_limpa) begin
                r_valid <= '0;
            end
            if (w_remove) begin
                r_valid[bus.remover_idx] <= 1'b0;
            end
            if (w_lat) begin
                r_lat_dir <= bus.direcao;
                r_lat_x   <= bus.nave_x;
                r_lat_y   <= bus.nave_y;
            end
            if (w_grava) begin
                r_valid[w_livre_idx] <= 1'b1;
                r_x[w_livre_idx]     <= r_lat_x;
                r_y[w_livre_idx]     <= r_lat_y;
                r_dir[w_livre_idx]   <= r_lat_dir;
            end
            if (w_zera_idx) begin
                r_idx <= '0;
            end
            if (w_passo) begin
                r_idx <= r_idx + IDX_W'(1);
                if (r_valid[r_idx]) begin
`ifdef TIROS_WRAP_EN
                    r_x[r_idx] <= w_novo_x;
                    r_y[r_idx] <= w_novo_y;
`else
                    if (w_sai) begin
                        r_valid[r_idx] <= 1'b0;
                    end else begin
                        r_x[r_idx] <= w_novo_x;
                        r_y[r_idx] <= w_novo_y;
                    end
`endif
                end
            end
        end
    end

    // Population count of valid slots, following the registered table
    always_comb begin
        w_num = '0;
        for (int i = 0; i < N; i++) begin
            w_num = w_num + CNT_W'(r_valid[i]);
        end
    end

    assign bus.consulta_x      = r_x[bus.consulta_idx];
    assign bus.consulta_y      = r_y[bus.consulta_idx];
    assign bus.consulta_valido = r_valid[bus.consulta_idx];
    assign bus.num_tiros       = w_num;
    assign bus.cheio           = (w_num == CNT_W'(N));
    assign bus.pronto          = r_pronto;
    assign bus.descartado      = r_descartado;
    assign bus.db_estado       = {1'b0, r_estado};
endmodule

// File: tb/tb_gerenciador_tiros_param.sv
// Directed bench for gerenciador_tiros_param (IDX_W=3, COORD_W=4).
module tb_gerenciador_tiros_param;
    localparam int OP_TIRO = 0;
    localparam int OP_MOVE = 1;
    localparam int OP_REM  = 2;
    localparam int OP_INI  = 3;
    localparam int OP_NOP  = 4;

    typedef struct {
        int         op;
        logic [1:0] dir;
        int         x;
        int         y;
        int         idx;
        int         probe;
        int         exp_v;
        int         exp_x;
        int         exp_y;
        int         exp_num;
        int         exp_lat;
        int         exp_desc;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    gerenciador_tiros_param_if #(.IDX_W(3), .COORD_W(4)) bus ();

    gerenciador_tiros_param #(.IDX_W(3), .COORD_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.iniciar     = 1'b0;
        bus.tiro        = 1'b0;
        bus.mover       = 1'b0;
        bus.remover     = 1'b0;
        bus.remover_idx = '0;
        bus.direcao     = '0;
        bus.nave_x      = '0;
        bus.nave_y      = '0;
    endtask

    function automatic vec_t mk(int op, int dir, int x, int y, int idx, int probe,
                                int ev, int ex, int ey, int en, int el, int ed);
        vec_t v;
        v.op = op; v.dir = 2'(dir); v.x = x; v.y = y; v.idx = idx;
        v.probe = probe; v.exp_v = ev; v.exp_x = ex; v.exp_y = ey;
        v.exp_num = en; v.exp_lat = el; v.exp_desc = ed;
        return v;
    endfunction

    task automatic probe(input int idx, input int ev, input int ex, input int ey, input int en);
        bus.consulta_idx = 3'(idx);
        #1;
        check("valido", int'(bus.consulta_valido), ev);
        if (ev != 0) begin
            check("coord_x", int'(bus.consulta_x), ex);
            check("coord_y", int'(bus.consulta_y), ey);
        end
        check("num_tiros", int'(bus.num_tiros), en);
        check("cheio", int'(bus.cheio), (en == 8) ? 1 : 0);
    endtask

    task automatic do_op(input vec_t v);
        int cnt;
        int saw_pr;
        int saw_desc;
        @(negedge clock);
        clear_inputs();
        case (v.op)
            OP_TIRO: begin
                bus.tiro = 1'b1; bus.direcao = v.dir;
                bus.nave_x = 4'(v.x); bus.nave_y = 4'(v.y);
            end
            OP_MOVE: bus.mover = 1'b1;
            OP_REM:  begin bus.remover = 1'b1; bus.remover_idx = 3'(v.idx); end
            OP_INI:  bus.iniciar = 1'b1;
            default: ;
        endcase
        cnt = 0; saw_pr = 0; saw_desc = 0;
        if (v.exp_lat > 0) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                cnt++;
                if (k == 0) clear_inputs();
                if (bus.descartado) saw_desc = 1;
                if (bus.pronto) begin
                    saw_pr = 1;
                    break;
                end
            end
            check("latencia_pronto", saw_pr != 0 ? cnt : -1, v.exp_lat);
            check("descartado", saw_desc, v.exp_desc);
            @(negedge clock);
            check("pronto_um_ciclo", int'(bus.pronto), 0);
            check("descartado_um_ciclo", int'(bus.descartado), 0);
        end else begin
            @(negedge clock);
            clear_inputs();
            check("sem_pronto", int'(bus.pronto), 0);
            check("estado_espera", int'(bus.db_estado), 1);
        end
        probe(v.probe, v.exp_v, v.exp_x, v.exp_y, v.exp_num);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        clear_inputs();
        bus.consulta_idx = '0;

        // Table: op, dir, x, y, idx, probe, exp valid/x/y, num, latency, descartado
        tbl.push_back(mk(OP_TIRO, 0, 5, 3, 0, 0, 1, 5, 3, 1, 2, 0));
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 0, 1, 5, 4, 1, 9, 0));
        tbl.push_back(mk(OP_TIRO, 1, 15, 7, 0, 1, 1, 15, 7, 2, 2, 0));
`ifdef TIROS_WRAP_EN
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 1, 1, 0, 7, 2, 9, 0));
        tbl.push_back(mk(OP_REM,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`else
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 1, 0, 0, 0, 1, 9, 0));
        tbl.push_back(mk(OP_REM,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        tbl.push_back(mk(OP_INI,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TIRO, 2, 4, 0, 0, 0, 1, 4, 0, 1, 2, 0));
        tbl.push_back(mk(OP_TIRO, 3, 0, 9, 0, 1, 1, 0, 9, 2, 2, 0));
        tbl.push_back(mk(OP_TIRO, 0, 2, 15, 0, 2, 1, 2, 15, 3, 2, 0));
`ifdef TIROS_WRAP_EN
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 0, 1, 4, 15, 3, 9, 0));
        tbl.push_back(mk(OP_NOP,  0, 0, 0, 0, 1, 1, 15, 9, 3, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 0, 0, 0, 2, 1, 2, 0, 3, 0, 0));
`else
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0));
        tbl.push_back(mk(OP_NOP,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(OP_NOP,  0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
`endif
        tbl.push_back(mk(OP_INI,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(OP_TIRO, 1, 3, 3, 0, 0, 1, 3, 3, 1, 2, 0));
        tbl.push_back(mk(OP_REM,  0, 0, 0, 5, 0, 1, 3, 3, 1, 0, 0));
        tbl.push_back(mk(OP_MOVE, 0, 0, 0, 0, 0, 1, 4, 3, 1, 9, 0));

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("rst_pronto", int'(bus.pronto), 0);
        check("rst_descartado", int'(bus.descartado), 0);
        check("rst_estado", int'(bus.db_estado), 0);
        for (int i = 0; i < 8; i++) probe(i, 0, 0, 0, 0);

        // Requests ignored in INICIAL
        bus.tiro = 1'b1; bus.mover = 1'b1;
        repeat (3) @(negedge clock);
        clear_inputs();
        check("inicial_ignora", int'(bus.db_estado), 0);
        check("inicial_num", int'(bus.num_tiros), 0);
        bus.iniciar = 1'b1;
        @(negedge clock);
        clear_inputs();
        check("iniciar_espera", int'(bus.db_estado), 1);

        foreach (tbl[i]) do_op(tbl[i]);

        // Fill the table, then one dropped shot
        do_op(mk(OP_INI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            do_op(mk(OP_TIRO, 0, i + 1, i, 0, i, 1, i + 1, i, i + 1, 2, 0));
        do_op(mk(OP_TIRO, 1, 9, 9, 0, 7, 1, 8, 7, 8, 2, 1));

        // remover outranks a simultaneous tiro
        @(negedge clock);
        bus.remover = 1'b1; bus.remover_idx = 3'd3; bus.tiro = 1'b1;
        bus.nave_x = 4'd9; bus.nave_y = 4'd9;
        @(negedge clock);
        clear_inputs();
        check("prio_estado", int'(bus.db_estado), 1);
        probe(3, 0, 0, 0, 7);

        // Reset in the middle of a move pass
        @(negedge clock);
        bus.mover = 1'b1;
        @(negedge clock);
        clear_inputs();
        repeat (2) @(negedge clock);
        check("move_ativo", int'(bus.db_estado), 3);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("rst_move_estado", int'(bus.db_estado), 0);
        check("rst_move_pronto", int'(bus.pronto), 0);
        probe(0, 0, 0, 0, 0);
        bus.tiro = 1'b1; bus.mover = 1'b1;
        repeat (4) @(negedge clock);
        clear_inputs();
        check("pos_rst_ignora", int'(bus.db_estado), 0);
        check("pos_rst_num", int'(bus.num_tiros), 0);
        bus.iniciar = 1'b1;
        @(negedge clock);
        clear_inputs();
        check("pos_rst_iniciar", int'(bus.db_estado), 1);
        v = mk(OP_TIRO, 3, 6, 2, 0, 0, 1, 6, 2, 1, 2, 0);
        do_op(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gerenciador_tiros_param.md
GERENCIADOR_TIROS_PARAM -- requirements
Module: gerenciador_tiros_param

Interface
REQ-001 The block SHALL have parameter IDX_W, default 3, meaning slot-index width; slot count N = 2**IDX_W.
REQ-002 The block SHALL have parameter COORD_W, default 4, meaning width of each x/y coordinate on a square grid of side 2**COORD_W.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port iniciar  input  1  start/clear request.
REQ-006 The block SHALL have port tiro  input  1  new-shot request.
REQ-007 The block SHALL have port direcao  input  2  shot direction: 00 up (y+1), 01 right (x+1), 10 down (y-1), 11 left (x-1).
REQ-008 The block SHALL have ports nave_x and nave_y  input  COORD_W each  ship position used as the new shot origin.
REQ-009 The block SHALL have port mover  input  1  request for one move pass over all slots.
REQ-010 The block SHALL have ports remover (input, 1) and remover_idx (input, IDX_W)  invalidate one slot.
REQ-011 The block SHALL have port consulta_idx  input  IDX_W  read-port slot select.
REQ-012 The block SHALL have ports consulta_x and consulta_y (output, COORD_W each) and consulta_valido (output, 1)  combinational read of the selected slot.
REQ-013 The block SHALL have port num_tiros  output  IDX_W+1  count of valid slots.
REQ-014 The block SHALL have ports cheio (output, 1, num_tiros==N), pronto (output, 1, one-cycle completion pulse), descartado (output, 1, one-cycle pulse on dropped shot), and db_estado (output, 4, FSM state code).

Function
REQ-015 The FSM SHALL have states INICIAL(0), ESPERA(1), REGISTRA(2), MOVE(3), FIM(4); db_estado SHALL show the code.
REQ-016 INICIAL: on iniciar=1, all slots SHALL be invalidated and the FSM SHALL go to ESPERA; otherwise it SHALL hold.
REQ-017 Requests SHALL be sampled only in ESPERA and ignored in all other states; priority iniciar > remover > tiro > mover.
REQ-018 In ESPERA, iniciar SHALL clear all slots that cycle and stay in ESPERA without pronto.
REQ-019 In ESPERA, remover SHALL clear the valid bit of slot remover_idx that cycle without pronto; removing an invalid slot SHALL be a no-op.
REQ-020 In ESPERA, tiro SHALL latch direcao, nave_x, nave_y and go to REGISTRA.
REQ-021 REGISTRA SHALL write the latched values into the lowest-index invalid slot and set it valid; if all slots are valid, it SHALL write nothing and pulse descartado; then go to FIM.
REQ-022 In ESPERA, mover SHALL reset the scan index to 0 and go to MOVE.
REQ-023 MOVE SHALL process one slot per cycle, index 0..N-1, stepping each valid slot by one cell in its direction; after slot N-1, it SHALL go to FIM (N cycles in MOVE).
REQ-024 A step leaving the grid (y=max going up, x=max going right, y=0 going down, x=0 going left) SHALL invalidate the slot, unless REQ-031 applies.
REQ-025 FIM SHALL assert pronto for exactly one cycle and return to ESPERA.
REQ-026 Latency: tiro accepted at cycle t SHALL produce pronto at t+2; mover accepted at t SHALL produce pronto at t+N+1.
REQ-027 num_tiros and cheio SHALL reflect slot contents registered on the current clock edge, with no lag.
REQ-028 Outputs after reset SHALL be: pronto=0, descartado=0, num_tiros=0, cheio=0, db_estado=0, all consulta_valido=0.

Reset
REQ-029 reset=0 at a rising edge SHALL force INICIAL, clear all valid bits, coordinates, directions, and the scan index, from any state, including mid-MOVE.
REQ-030 Reset SHALL have priority over every other input.

Configuration
REQ-031 With macro TIROS_WRAP_EN defined, an out-of-grid step SHALL wrap modulo 2**COORD_W (e.g. x=max right -> x=0) and keep the slot valid; without it, REQ-024 invalidation SHALL apply.

Verification
REQ-032 Reset, iniciar pulse, tiro with direcao=00 and nave=(5,3) -> pronto 2 cycles later; slot 0 = (5,3) valid; num_tiros=1.
REQ-033 Then mover -> pronto N+1=9 cycles after acceptance; slot 0 = (5,4).
REQ-034 8 tiro requests fill the table, cheio=1; 9th tiro -> descartado pulse, num_tiros stays 8.
REQ-035 Shot at (15,7) direcao=01, mover -> slot invalidated without macro; slot = (0,7) valid with TIROS_WRAP_EN.
REQ-036 remover with remover_idx=0 while slot 0 is valid -> consulta_valido=0 for index 0 the next cycle; num_tiros decrements by 1.
REQ-037 reset=0 asserted mid-MOVE -> db_estado=0 and num_tiros=0 the next cycle; tiro/mover ignored until iniciar.
